// File: rtl/fpu_issue_unit.sv
// FP register file plus issue/write-back sequencer in front of the FPU exec element.
// Optional WAIT-state abort (for ops that never complete) is enabled by defining FPU_ISSUE_TIMEOUT_EN.
module fpu_issue_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_inst_num,
    input  logic [4:0]  req_fs_num,
    input  logic [4:0]  req_ft_num,
    input  logic [4:0]  req_fd_num,
    output logic        exec_reset,
    input  logic        exec_completed,
    output logic [5:0]  exec_inst_num,
    output logic [31:0] exec_fs,
    output logic [31:0] exec_ft,
    input  logic [31:0] exec_out,
    input  logic        wr_en,
    input  logic [4:0]  wr_num,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_num,
    output logic [31:0] rd_data,
    output logic        wb_valid,
    output logic [4:0]  wb_fd_num,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] rf_q [32];
    logic [5:0]  inst_q, inst_d;
    logic [31:0] fs_q, fs_d;
    logic [31:0] ft_q, ft_d;
    logic [4:0]  fd_q, fd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_fd_q, wb_fd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        rf_wb_en;

`ifdef FPU_ISSUE_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
`else
    logic        unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        fs_d       = fs_q;
        ft_d       = ft_q;
        fd_d       = fd_q;
        wb_valid_d = 1'b0;
        wb_fd_d    = wb_fd_q;
        wb_data_d  = wb_data_q;
        rf_wb_en   = 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    inst_d  = req_inst_num;
                    fd_d    = req_fd_num;
                    // Same-cycle external write is forwarded into the operand latch.
                    fs_d    = (wr_en && wr_num == req_fs_num) ? wr_data : rf_q[req_fs_num];
                    ft_d    = (wr_en && wr_num == req_ft_num) ? wr_data : rf_q[req_ft_num];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
`ifdef FPU_ISSUE_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (exec_completed) begin
                    rf_wb_en   = (inst_q >= 6'd54) && (inst_q <= 6'd62);
                    wb_data_d  = exec_out;
                    wb_fd_d    = fd_q;
                    wb_valid_d = 1'b1;
                    state_d    = DONE;
                end
`ifdef FPU_ISSUE_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == 16'(TIMEOUT_CYCLES)) begin
                        wb_data_d  = 32'h7FC00000;
                        wb_fd_d    = fd_q;
                        wb_valid_d = 1'b1;
                        timeout_d  = 1'b1;
                        state_d    = DONE;
                    end
                end
`endif
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            inst_q     <= '0;
            fs_q       <= '0;
            ft_q       <= '0;
            fd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_fd_q    <= '0;
            wb_data_q  <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
`ifdef FPU_ISSUE_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            fs_q       <= fs_d;
            ft_q       <= ft_d;
            fd_q       <= fd_d;
            wb_valid_q <= wb_valid_d;
            wb_fd_q    <= wb_fd_d;
            wb_data_q  <= wb_data_d;
`ifdef FPU_ISSUE_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
            // Write-back is issued last so it overrides an external write to the same register.
            if (wr_en)    rf_q[wr_num] <= wr_data;
            if (rf_wb_en) rf_q[fd_q]   <= exec_out;
        end
    end

    assign exec_reset    = reset || (state_q == LAUNCH);
    assign req_ready     = (state_q == IDLE) && !reset;
    assign busy          = (state_q != IDLE);
    assign exec_inst_num = inst_q;
    assign exec_fs       = fs_q;
    assign exec_ft       = ft_q;
    assign rd_data       = rf_q[rd_num];
    assign wb_valid      = wb_valid_q;
    assign wb_fd_num     = wb_fd_q;
    assign wb_data       = wb_data_q;
`ifdef FPU_ISSUE_TIMEOUT_EN
    assign timeout       = timeout_q;
`else
    assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_unit.sv
// Scoreboard bench for fpu_issue_unit: a behavioural exec-element model and register-file model
// predict every write-back; a monitor process pops and compares each wb_valid pulse.
module tb_fpu_issue_unit;
`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [5:0]  req_inst_num = '0;
    logic [4:0]  req_fs_num = '0, req_ft_num = '0, req_fd_num = '0;
    logic        exec_reset, exec_completed = 1'b0;
    logic [5:0]  exec_inst_num;
    logic [31:0] exec_fs, exec_ft, exec_out = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_num = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd_num = '0;
    logic [31:0] rd_data;
    logic        wb_valid;
    logic [4:0]  wb_fd_num;
    logic [31:0] wb_data;
    logic        busy, timeout;

    fpu_issue_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_inst_num(req_inst_num), .req_fs_num(req_fs_num), .req_ft_num(req_ft_num),
        .req_fd_num(req_fd_num), .exec_reset(exec_reset), .exec_completed(exec_completed),
        .exec_inst_num(exec_inst_num), .exec_fs(exec_fs), .exec_ft(exec_ft), .exec_out(exec_out),
        .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data), .rd_num(rd_num), .rd_data(rd_data),
        .wb_valid(wb_valid), .wb_fd_num(wb_fd_num), .wb_data(wb_data), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  inst;
        logic [4:0]  fd;
        logic [31:0] a, b, data;
        bit          writes, to;
        int          acc, lat;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    logic [31:0] rf_m [32];
    int          checks = 0, failures = 0, cyc = 0, cur_lat = 1, en = 0;
    logic [5:0]  r_inst;
    int          r_lat;
    bit          all_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic real sp2r(input logic [31:0] x);
        real m = 1.0 + real'(x[22:0]) / 8388608.0;
        int  e = int'(x[30:23]) - 127;
        if (x[30:0] == 31'd0) return 0.0;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2sp(input real v);
        logic        s = (v < 0.0);
        int          e = 127;
        logic [22:0] man;
        if (v == 0.0) return 32'd0;
        if (s) v = -v;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        man = 23'($rtoi((v - 1.0) * 8388608.0));
        return {s, 8'(e), man};
    endfunction

    // Exec-element behaviour: ABS, NEG, ADD, MOV exact; other numbers use an arbitrary mix.
    function automatic logic [31:0] ref_op(input logic [5:0] inst, input logic [31:0] a, input logic [31:0] b);
        case (inst)
            6'd54:   return {1'b0, a[30:0]};
            6'd55:   return {~a[31], a[30:0]};
            6'd56:   return r2sp(sp2r(a) + sp2r(b));
            6'd62:   return a;
            default: return (a ^ {b[15:0], b[31:16]}) + 32'(inst);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (reset) begin
            q.delete();
            foreach (rf_m[i]) rf_m[i] = '0;
        end else if (wr_en) begin
            rf_m[wr_num] = wr_data;
        end
        @(negedge clk);
    endtask

    task automatic accept_model(input int lat);
        exp_t e;
        if (!(req_valid && req_ready)) return;
        e.inst   = req_inst_num;
        e.fd     = req_fd_num;
        e.a      = (wr_en && wr_num == req_fs_num) ? wr_data : rf_m[req_fs_num];
        e.b      = (wr_en && wr_num == req_ft_num) ? wr_data : rf_m[req_ft_num];
        e.writes = (req_inst_num >= 6'd54) && (req_inst_num <= 6'd62);
        e.data   = ref_op(req_inst_num, e.a, e.b);
        e.to     = 1'b0;
        if (req_inst_num == 6'd63) begin
            e.data = 32'h7FC00000;
            e.to   = 1'b1;
        end
        e.acc   = cyc;
        e.lat   = lat;
        cur_lat = lat;
        q.push_back(e);
    endtask

    task automatic issue(input logic [5:0] inst, input logic [4:0] fs, input logic [4:0] ft,
                         input logic [4:0] fd, input int lat);
        chk("ready_before_issue", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_inst_num = inst;
        req_fs_num = fs; req_ft_num = ft; req_fd_num = fd;
        accept_model(lat);
        tick();
        req_valid = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic wr(input logic [4:0] n, input logic [31:0] d);
        wr_en = 1'b1; wr_num = n; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_wb();
        for (int k = 0; k < 200 && !wb_valid; k++) tick();
        chk("wb_seen_within_bound", 32'(wb_valid), 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && busy; k++) tick();
        chk("idle_within_bound", 32'(busy), 32'd0);
    endtask

    // Exec-element model and write-back monitor.
    initial forever begin
        @(negedge clk);
        if (exec_reset) en = 0;
        else begin
            en++;
            exec_completed = (en > cur_lat) && (exec_inst_num != 6'd63);
        end
        exec_out = ref_op(exec_inst_num, exec_fs, exec_ft);

        if (q.size() > 0 && cyc == q[0].acc + 1)
            chk("launch_exec_reset", 32'(exec_reset), 32'd1);
        if (busy && !exec_reset && !wb_valid && q.size() > 0) begin
            chk("hold_exec_inst", 32'(exec_inst_num), 32'(q[0].inst));
            chk("hold_exec_fs", exec_fs, q[0].a);
            chk("hold_exec_ft", exec_ft, q[0].b);
        end
        if (wb_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wb: got wb_valid=1 fd=%0d data=%h expected no write-back", wb_fd_num, wb_data);
            end else begin
                me = q.pop_front();
                chk("wb_fd_num", 32'(wb_fd_num), 32'(me.fd));
                chk("wb_data", wb_data, me.data);
                chk("wb_timeout", 32'(timeout), 32'(me.to));
                if (!me.to) chk("wb_latency", 32'(cyc), 32'(me.acc + me.lat + 3));
                if (me.writes) rf_m[me.fd] = me.data;
            end
        end
    end

    initial begin
        @(negedge clk);
        chk("reset_exec_reset", 32'(exec_reset), 32'd1);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_fd", 32'(wb_fd_num), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_exec_inst", 32'(exec_inst_num), 32'd0);
        chk("rst_exec_fs", exec_fs, 32'd0);
        chk("rst_exec_ft", exec_ft, 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_exec_reset_low", 32'(exec_reset), 32'd0);
        rd_num = 5'd17;
        #1 chk("rst_rf_zero", rd_data, 32'd0);
        tick();

        // ABS of -3.0, 1-cycle element
        wr(5'd1, 32'hC0400000);
        issue(6'd54, 5'd1, 5'd0, 5'd2, 1);
        wait_wb();
        rd_num = 5'd2;
        #1 chk("abs_rd_in_done", rd_data, 32'h40400000);
        wait_idle();

        // ADD 1.0 + 2.0, 10-cycle element
        wr(5'd3, 32'h3F800000);
        wr(5'd4, 32'h40000000);
        issue(6'd56, 5'd3, 5'd4, 5'd5, 10);
        wait_wb();
        rd_num = 5'd5;
        #1 chk("add_rd", rd_data, 32'h40400000);
        wait_idle();

        // Same-cycle bypass into the operand latch
        wr_en = 1'b1; wr_num = 5'd6; wr_data = 32'h12345678;
        issue(6'd62, 5'd6, 5'd0, 5'd7, 1);
        chk("bypass_exec_fs", exec_fs, 32'h12345678);
        wait_wb();
        rd_num = 5'd7;
        #1 chk("bypass_mov_rd", rd_data, 32'h12345678);
        wait_idle();

        // External write colliding with write-back on the same register
        wr(5'd8, 32'h00001111);
        issue(6'd62, 5'd8, 5'd0, 5'd9, 3);
        repeat (4) tick();
        wr_en = 1'b1; wr_num = 5'd9; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        rd_num = 5'd9;
        #1 chk("collide_wb_wins", rd_data, 32'h00001111);
        wait_idle();

        // External write to a different register at the write-back edge
        issue(6'd62, 5'd8, 5'd0, 5'd10, 3);
        repeat (4) tick();
        wr_en = 1'b1; wr_num = 5'd11; wr_data = 32'hCAFEF00D;
        tick();
        wr_en = 1'b0;
        rd_num = 5'd10;
        #1 chk("both_wb_reg", rd_data, 32'h00001111);
        rd_num = 5'd11;
        #1 chk("both_ext_reg", rd_data, 32'hCAFEF00D);
        wait_idle();

        // Reset two cycles into WAIT abandons the instruction
        wr(5'd12, 32'hA5A5A5A5);
        issue(6'd55, 5'd12, 5'd0, 5'd13, 10);
        repeat (2) tick();
        reset = 1'b1;
        #1 chk("midop_exec_reset", 32'(exec_reset), 32'd1);
        tick();
        reset = 1'b0;
        #1 chk("ready_after_reset", 32'(req_ready), 32'd1);
        repeat (15) tick();
        rd_num = 5'd13;
        #1 chk("reset_target_unchanged", rd_data, 32'd0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r_inst = 6'($urandom_range(0, 62));
            if (r_inst == 6'd56) r_inst = 6'd57;
            r_lat        = int'($urandom_range(1, 6));
            req_valid    = ($urandom_range(0, 1) == 1);
            req_inst_num = r_inst;
            req_fs_num   = 5'($urandom);
            req_ft_num   = 5'($urandom);
            req_fd_num   = 5'($urandom);
            wr_en        = ($urandom_range(0, 2) == 0);
            wr_num       = ($urandom_range(0, 1) == 1) ? req_fs_num : 5'($urandom);
            wr_data      = $urandom;
            rd_num       = 5'($urandom);
            accept_model(r_lat);
            #1 chk("rd_data", rd_data, rf_m[rd_num]);
            tick();
        end
        req_valid = 1'b0;
        wr_en     = 1'b0;
        wait_idle();
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        // SQRT.S never completes
        wr(5'd14, 32'h13579BDF);
`ifdef FPU_ISSUE_TIMEOUT_EN
        issue(6'd63, 5'd14, 5'd14, 5'd14, 1);
        wait_wb();
        rd_num = 5'd14;
        #1 chk("timeout_fd_unchanged", rd_data, 32'h13579BDF);
        wait_idle();
        chk("timeout_one_cycle", 32'(timeout), 32'd0);
`else
        issue(6'd63, 5'd14, 5'd14, 5'd14, 1);
        all_busy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (!busy) all_busy = 1'b0;
            tick();
        end
        chk("sqrt_stays_busy", 32'(all_busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 chk("sqrt_reset_recovers", 32'(busy), 32'd0);
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_issue_unit.md
# fpu_issue_unit

Issue and write-back stage directly upstream of the FPU ALU exec element. It holds the 32×32-bit FP register file and accepts one decoded FP instruction at a time. It reads the `fs`/`ft` operands, restarts the exec element with a one-cycle reset pulse, holds operands stable until the element's `completed` rises, then writes the result to `fd` and reports the write-back.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in WAIT before abort. Used only with `FPU_ISSUE_TIMEOUT_EN`. Range 1–65535.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: decoded FP instruction present.
- `req_ready` out 1: unit accepts request this cycle.
- `req_inst_num` in 6: instruction number; 54–63 are FP ALU ops.
- `req_fs_num`, `req_ft_num`, `req_fd_num` in 5 each: register indices.
- `exec_reset` out 1: reset/start to the exec element.
- `exec_completed` in 1: exec element done flag.
- `exec_inst_num` out 6: latched instruction number.
- `exec_fs` out 32, `exec_ft` out 32: latched operands.
- `exec_out` in 32: exec element result.
- `wr_en` in 1, `wr_num` in 5, `wr_data` in 32: external register write (MTC1/LWC1).
- `rd_num` in 5, `rd_data` out 32: combinational read port (MFC1/SWC1).
- `wb_valid` out 1: one-cycle write-back pulse.
- `wb_fd_num` out 5, `wb_data` out 32: write-back destination and value.
- `busy` out 1: high in any state other than IDLE.
- `timeout` out 1: abort indication; constant 0 without the macro.

## Operation
- FSM states: IDLE → LAUNCH → WAIT → DONE → IDLE.
- **IDLE**
  - `req_ready = 1`.
  - On `req_valid && req_ready`:
    - latch `req_inst_num` into `exec_inst_num`, and latch `req_fd_num`;
    - latch `exec_fs = RF[req_fs_num]` and `exec_ft = RF[req_ft_num]`, with bypass: if `wr_en` is high this cycle and `wr_num` matches, the operand takes `wr_data`;
    - go to LAUNCH.
- **LAUNCH**
  - `exec_reset = 1` for exactly this cycle.
  - `exec_completed` is ignored because it may be stale.
  - Go to WAIT.
- **WAIT**
  - `exec_inst_num`, `exec_fs` and `exec_ft` stay constant.
  - On `exec_completed = 1`:
    - if `exec_inst_num` is in 54–62, write `RF[fd] <= exec_out` at this edge;
    - register `wb_data <= exec_out` and `wb_fd_num <= fd`;
    - go to DONE.
- **DONE**
  - `wb_valid = 1`, `req_ready = 0`.
  - Go to IDLE.
  - `wb_valid` pulses for every instruction, including numbers outside 54–62, which leave RF unchanged.
- `exec_reset = reset || (state == LAUNCH)`.
- `req_ready = (state == IDLE) && !reset`.
- External write port:
  - `RF[wr_num] <= wr_data` whenever `wr_en` is high, in any state.
  - If it hits the same register as an RF write-back at the same edge, the write-back wins.
  - Writes to different registers both take effect.
- `rd_data = RF[rd_num]` combinationally; there is no bypass on this port.
- All 32 registers, including f0, are writable.

## Timing
- Reset values:
  - state IDLE, all RF entries 0;
  - `wb_valid`, `wb_fd_num`, `wb_data`, `exec_inst_num`, `exec_fs`, `exec_ft`, `timeout` all 0;
  - `exec_reset` 1 and `req_ready` 0 while `reset` is high.
- Reset mid-operation: abandons the instruction with no RF write and no `wb_valid`. State returns to IDLE on the next edge.
- Sequence for an acceptance at edge E:
  - LAUNCH occupies cycle E+1.
  - The exec element's `completed` is 0 in E+2 at the earliest.
  - For a 1-cycle op (ABS/NEG/MOV), `completed` is 1 in E+3, DONE is E+4, and a new request can be accepted at E+5.
- Minimum issue interval: 5 cycles. For IP ops (add/mul/div/cvt) it is the IP latency plus 4.
- Data written at the end of WAIT is visible on `rd_data` during DONE.

## Configuration
- Macro: `FPU_ISSUE_TIMEOUT_EN`.
- Defined:
  - a 16-bit counter clears on entry to WAIT and increments each WAIT cycle;
  - when the count reaches `TIMEOUT_CYCLES` with `exec_completed` still 0, go to DONE with `wb_data = 32'h7FC00000` and `timeout = 1` for the DONE cycle only;
  - the RF is not written;
  - this covers SQRT.S (63), which never completes.
- Undefined: WAIT lasts indefinitely until `exec_completed`; `timeout` is tied to 0.

## Test plan
- Preload f1 = 0xC0400000 via the write port, issue inst 54 with fs=1, fd=2 → `exec_reset` pulses at E+1, `wb_valid` at E+4 with `wb_fd_num` = 2 and `wb_data` = 0x40400000, and `rd_num` = 2 reads 0x40400000.
- Issue inst 56 with f3 = 0x3F800000, f4 = 0x40000000, fd=5, with a model exec element of 10-cycle latency → `exec_fs`/`exec_ft` are stable through WAIT and `wb_data` = 0x40400000.
- Same-cycle bypass: `wr_en` with f6 = 0x12345678 in the acceptance cycle of inst 62 with fs=6 → `exec_fs` = 0x12345678 and f7 = 0x12345678 afterwards.
- Write-back and external write to the same register at the same edge → RF holds the write-back value. With different registers, both values are present.
- `reset` asserted 2 cycles into WAIT → no `wb_valid`, target register unchanged, `req_ready` = 1 the cycle after `reset` deasserts.
- With `FPU_ISSUE_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, issue inst 63 → `timeout` = 1, `wb_valid` = 1 with 0x7FC00000, and fd unchanged. Without the macro, `busy` stays 1.
